// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, one-deep outstanding read tracking
// against a synchronous-read instruction memory, and the IF/ID register.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        stall,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] instr_out,
   output logic [31:0] pc4_out,
   output logic        valid_out,
   output logic [5:0]  opcode_out,
   output logic        ctrl_ena
);

   // EMPTY: no read in flight; PENDING: imem_data answers resp_addr
   typedef enum logic {EMPTY = 1'b0, PENDING = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [31:0] resp_addr;
   logic        resp_valid;
   logic        redirect;
   logic        advance;
   logic [31:0] target;

   assign resp_valid = (state == PENDING);
   assign redirect   = ena & (jump | branch_taken);
   assign advance    = ena & ~stall & ~redirect;
   // jump wins over a simultaneous branch; targets are word aligned
   assign target     = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;

   assign imem_en    = ena;
   // while stalled, re-read the in-flight address so the held response stays valid
   assign imem_addr  = (stall && resp_valid) ? resp_addr : pc;
   assign opcode_out = instr_out[31:26];
   assign ctrl_ena   = ena & ~stall;

   // next-state: a redirect drops the in-flight read, an advance starts a new one
   always_comb begin
      state_nxt = state;
      if (redirect)
         state_nxt = EMPTY;
      else if (advance)
         state_nxt = PENDING;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   // PC and address of the read in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         resp_addr <= RESET_PC;
      end else if (redirect) begin
         pc        <= target;
      end else if (advance) begin
         resp_addr <= pc;
         pc        <= pc + 32'd4;
      end
   end

   // IF/ID register: flush on redirect, capture the response on advance
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_out <= NOP_INSTR;
         pc4_out   <= 32'd0;
         valid_out <= 1'b0;
      end else if (redirect) begin
         instr_out <= NOP_INSTR;
         valid_out <= 1'b0;
      end else if (advance) begin
         instr_out <= resp_valid ? imem_data : NOP_INSTR;
         valid_out <= resp_valid;
         pc4_out   <= resp_addr + 32'd4;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; instruction memory returns ~address.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, ena, stall, jump, branch_taken;
   logic [31:0] jump_target, branch_target;
   logic        imem_en;
   logic [31:0] imem_addr, imem_data, instr_out, pc4_out;
   logic        valid_out, ctrl_ena;
   logic [5:0]  opcode_out;

   // second instance exercising PC wraparound
   logic        rst2;
   logic        imem_en2, valid_out2, ctrl_ena2;
   logic [31:0] imem_addr2, imem_data2, instr_out2, pc4_out2;
   logic [5:0]  opcode_out2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .ena(ena), .stall(stall),
      .jump(jump), .jump_target(jump_target),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
      .instr_out(instr_out), .pc4_out(pc4_out), .valid_out(valid_out),
      .opcode_out(opcode_out), .ctrl_ena(ctrl_ena));

   if_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut2 (
      .clk(clk), .rst(rst2), .ena(1'b1), .stall(1'b0),
      .jump(1'b0), .jump_target(32'h0),
      .branch_taken(1'b0), .branch_target(32'h0),
      .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_data(imem_data2),
      .instr_out(instr_out2), .pc4_out(pc4_out2), .valid_out(valid_out2),
      .opcode_out(opcode_out2), .ctrl_ena(ctrl_ena2));

   // synchronous-read memories, content = ~address
   always @(posedge clk) begin
      if (imem_en)  imem_data  <= ~imem_addr;
      if (imem_en2) imem_data2 <= ~imem_addr2;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, ena, stall, jump;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic        chk_pre;
      logic [31:0] addr, instr, pc4;
      logic        valid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic e, logic s, logic j, logic [31:0] jt,
                               logic b, logic [31:0] bt, logic cp, logic [31:0] a,
                               logic [31:0] i, logic [31:0] p, logic v);
      vec_t t;
      t.rst = r; t.ena = e; t.stall = s; t.jump = j; t.jt = jt; t.br = b; t.bt = bt;
      t.chk_pre = cp; t.addr = a; t.instr = i; t.pc4 = p; t.valid = v;
      return t;
   endfunction

   initial begin
      rst = 1'b1; ena = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      jump_target = 32'h0; branch_target = 32'h0; rst2 = 1'b1;

      //           rst ena stl jmp jt       br bt       pre addr          instr         pc4           v
      vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,        NOP,          32'h0,        0));
      vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,        NOP,          32'h0,        0));
      // reset release, sequential fetch
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,        NOP,          32'h4,        0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h4,        32'hFFFFFFFF, 32'h4,        1));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h8,        32'hFFFFFFFB, 32'h8,        1));
      // three stall cycles: re-read of in-flight address, outputs hold
      vecs.push_back(mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h8,        32'hFFFFFFFB, 32'h8,        1));
      vecs.push_back(mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h8,        32'hFFFFFFFB, 32'h8,        1));
      vecs.push_back(mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h8,        32'hFFFFFFFB, 32'h8,        1));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'hC,        32'hFFFFFFF7, 32'hC,        1));
      // jump during stall, misaligned target
      vecs.push_back(mk(0, 1, 1, 1, 32'h103, 0, 32'h0,   1, 32'hC,        NOP,          32'hC,        0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h100,      NOP,          32'h10,       0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h104,      32'hFFFFFEFF, 32'h104,      1));
      // jump and branch together: jump wins
      vecs.push_back(mk(0, 1, 0, 1, 32'h200, 1, 32'h300, 1, 32'h108,      NOP,          32'h104,      0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h200,      NOP,          32'h108,      0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h204,      32'hFFFFFDFF, 32'h204,      1));
      // branch alone, misaligned target
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'h302, 1, 32'h208,      NOP,          32'h204,      0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h300,      NOP,          32'h208,      0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h304,      32'hFFFFFCFF, 32'h304,      1));
      // ena low with jump: ignored, everything frozen
      vecs.push_back(mk(0, 0, 0, 1, 32'h500, 0, 32'h0,   1, 32'h308,      32'hFFFFFCFF, 32'h304,      1));
      vecs.push_back(mk(0, 0, 0, 1, 32'h500, 0, 32'h0,   1, 32'h308,      32'hFFFFFCFF, 32'h304,      1));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h308,      32'hFFFFFCFB, 32'h308,      1));
      // reset mid-stall, then two edges to the first valid
      vecs.push_back(mk(1, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h308,      NOP,          32'h0,        0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,        NOP,          32'h4,        0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h4,        32'hFFFFFFFF, 32'h4,        1));

      foreach (vecs[k]) begin
         @(negedge clk);
         rst = vecs[k].rst; ena = vecs[k].ena; stall = vecs[k].stall;
         jump = vecs[k].jump; jump_target = vecs[k].jt;
         branch_taken = vecs[k].br; branch_target = vecs[k].bt;
         #1;
         if (vecs[k].chk_pre) begin
            chk($sformatf("v%0d imem_addr", k), imem_addr, vecs[k].addr);
            chk($sformatf("v%0d imem_en", k), {31'd0, imem_en}, {31'd0, vecs[k].ena});
            chk($sformatf("v%0d ctrl_ena", k), {31'd0, ctrl_ena},
                {31'd0, vecs[k].ena & ~vecs[k].stall});
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d instr_out", k), instr_out, vecs[k].instr);
         chk($sformatf("v%0d pc4_out", k), pc4_out, vecs[k].pc4);
         chk($sformatf("v%0d valid_out", k), {31'd0, valid_out}, {31'd0, vecs[k].valid});
         chk($sformatf("v%0d opcode_out", k), {26'd0, opcode_out}, {26'd0, vecs[k].instr[31:26]});
      end

      // wraparound sequence on the second instance
      @(negedge clk);
      rst2 = 1'b0;
      #1 chk("wrap addr0", imem_addr2, 32'hFFFF_FFF8);
      @(posedge clk); #1;
      chk("wrap e1 valid", {31'd0, valid_out2}, 32'd0);
      chk("wrap e1 pc4", pc4_out2, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap addr1", imem_addr2, 32'hFFFF_FFFC);
      @(posedge clk); #1;
      chk("wrap e2 instr", instr_out2, 32'h0000_0007);
      chk("wrap e2 pc4", pc4_out2, 32'hFFFF_FFFC);
      chk("wrap e2 valid", {31'd0, valid_out2}, 32'd1);
      @(negedge clk);
      chk("wrap addr2", imem_addr2, 32'h0000_0000);
      @(posedge clk); #1;
      chk("wrap e3 instr", instr_out2, 32'h0000_0003);
      chk("wrap e3 pc4", pc4_out2, 32'h0000_0000);
      @(negedge clk);
      chk("wrap addr3", imem_addr2, 32'h0000_0004);
      @(posedge clk); #1;
      chk("wrap e4 instr", instr_out2, 32'hFFFF_FFFF);
      chk("wrap e4 pc4", pc4_out2, 32'h0000_0004);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of first fetched instruction.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word inserted on bubbles and flushes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ena  input  1  global stage enable; 0 freezes all state.
REQ-006 stall  input  1  hazard stall from decode; holds PC and IF/ID register.
REQ-007 jump  input  1  jump redirect request.
REQ-008 jump_target  input  32  jump destination byte address.
REQ-009 branch_taken  input  1  resolved taken-branch redirect request.
REQ-010 branch_target  input  32  branch destination byte address.
REQ-011 imem_en  output  1  instruction-memory read enable, combinational, equal to ena.
REQ-012 imem_addr  output  32  instruction-memory read address, combinational.
REQ-013 imem_data  input  32  synchronous-read memory data, valid one cycle after the address is presented with imem_en=1.
REQ-014 instr_out  output  32  IF/ID registered instruction word.
REQ-015 pc4_out  output  32  IF/ID registered address of that instruction plus 4.
REQ-016 valid_out  output  1  IF/ID entry holds a real instruction.
REQ-017 opcode_out  output  6  instr_out[31:26], combinational, feeds the control unit opcode input.
REQ-018 ctrl_ena  output  1  ena & ~stall, combinational, feeds the control unit enable.

Function
REQ-019 Internal state: pc (next address to issue), resp_valid, resp_addr (address of the read in flight); resp_valid=0 is state EMPTY, resp_valid=1 is state PENDING.
REQ-020 imem_addr = resp_addr when stall=1 and resp_valid=1, else pc; on stall this re-reads the in-flight address so imem_data remains valid for the held response.
REQ-021 Redirect = ena & (jump | branch_taken); jump has priority over branch_taken when both are asserted; target bits [1:0] are forced to 0.
REQ-022 Redirect edge: pc <= target; resp_valid <= 0; instr_out <= NOP_INSTR; valid_out <= 0; pc4_out holds; redirect overrides stall.
REQ-023 Advance edge (ena=1, stall=0, no redirect): instr_out <= resp_valid ? imem_data : NOP_INSTR; valid_out <= resp_valid; pc4_out <= resp_addr + 4; resp_addr <= pc; resp_valid <= 1; pc <= pc + 4.
REQ-024 Stall edge (ena=1, stall=1, no redirect): pc, resp_valid, resp_addr and all IF/ID outputs hold.
REQ-025 ena=0: all registers hold and redirect/stall inputs are ignored.
REQ-026 Additions are modulo 2^32; pc 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-027 Latency: target instruction appears on instr_out with valid_out=1 at the second advance edge after the redirect edge; exactly two bubbles per redirect without stalls.
REQ-028 Throughput: one valid instruction per advance edge while in PENDING with no redirects.

Reset
REQ-029 rst=1 at an edge has priority over everything else: pc <= RESET_PC; resp_valid <= 0; resp_addr <= RESET_PC; instr_out <= NOP_INSTR; pc4_out <= 0; valid_out <= 0.
REQ-030 Reset asserted mid-stall or mid-redirect discards all in-flight state; the first valid_out=1 occurs at the second advance edge after rst deasserts.

Verification
REQ-031 Reset release with mem[0]=A, mem[4]=B, no stall: valid_out sequence 0,1,1 over edges 1-3; instr_out=A with pc4_out=4, then B with pc4_out=8.
REQ-032 Stall held 3 cycles while instr_out=B: instr_out, pc4_out and valid_out stay fixed; imem_addr=resp_addr during stall; after release, next instr_out=mem[8] with no skip or duplicate.
REQ-033 jump=1, jump_target=32'h0000_0103 with stall=1: flush occurs, imem_addr=32'h100 next cycle, then two bubbles, then instr_out=mem[0x100], pc4_out=32'h104.
REQ-034 jump and branch_taken asserted together (targets 0x200 and 0x300): fetch proceeds from 0x200.
REQ-035 RESET_PC=32'hFFFF_FFF8, run 3 advances: issued addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000; pc4_out of the second instruction is 0.
REQ-036 ena=0 for 2 cycles with jump=1: no state change, imem_en=0; after ena returns with jump=0, fetch resumes sequentially.
